// File: rtl/q65_sweep_ctrl.sv
// Exhaustive-stimulus sequencer: walks an NSIG-bit vector through NTICKS values over valid/ready.
// Define Q65_SWEEP_MISR_EN to fold each accepted response into a 32-bit MISR signature.
module q65_sweep_ctrl #(
    parameter int unsigned NSIG      = 1,
    parameter int unsigned NTICKS    = 32'(1) << NSIG,
    parameter int unsigned RW        = 8,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] MISR_POLY = 32'h04C11DB7,
    parameter logic [31:0] MISR_SEED = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [NSIG-1:0] vec,
    output logic            vec_valid,
    input  logic            vec_ready,
    input  logic [RW-1:0]   resp,
    input  logic            resp_valid,
    output logic [31:0]     tick,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [31:0]     signature
);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT_RESP, DONE} state_t;

    localparam logic [31:0] TICK_LAST = 32'(NTICKS - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] timer;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= '0;
            vec_valid <= 1'b0;
            tick      <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            timer     <= 32'd0;
        end else if (abort) begin
            state     <= IDLE;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DRIVE;
                        vec       <= '0;
                        tick      <= 32'd0;
                        vec_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (vec_ready) begin
                        state     <= WAIT_RESP;
                        vec_valid <= 1'b0;
                        timer     <= 32'd0;
                    end
                end
                WAIT_RESP: begin
                    if (resp_valid) begin
                        tick <= sat_inc(tick);
                        if (tick == TICK_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // vec wraps naturally when NTICKS exceeds 2^NSIG
                            vec       <= vec + NSIG'(1);
                            vec_valid <= 1'b1;
                            state     <= DRIVE;
                        end
                    end else if (timer == TMO_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef Q65_SWEEP_MISR_EN
    logic start_go;
    logic resp_acc;

    assign start_go = start & ~abort & ((state == IDLE) | (state == DONE));
    assign resp_acc = resp_valid & ~abort & (state == WAIT_RESP);

    function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [RW-1:0] r);
        return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0) ^ 32'(r);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || start_go) begin
            signature <= MISR_SEED;
        end else if (resp_acc) begin
            signature <= misr_next(signature, resp);
        end
    end
`else
    logic unused_resp;

    assign unused_resp = ^resp;
    assign signature   = 32'h0;
`endif

endmodule

// File: tb/tb_q65_sweep_ctrl.sv
// Randomized bench for q65_sweep_ctrl, checked against a transaction-level sweep model.
module tb_q65_sweep_ctrl;

    localparam int unsigned NSIG    = 2;
    localparam int unsigned NTICKS  = 6;
    localparam int unsigned RW      = 8;
    localparam int unsigned TIMEOUT = 4;
    localparam logic [31:0] POLY    = 32'h04C11DB7;
    localparam logic [31:0] SEED    = 32'h1234_5678;

    logic            clk;
    logic            rst;
    logic            start;
    logic            abort;
    logic [NSIG-1:0] vec;
    logic            vec_valid;
    logic            vec_ready;
    logic [RW-1:0]   resp;
    logic            resp_valid;
    logic [31:0]     tick;
    logic            busy;
    logic            done;
    logic            err;
    logic [31:0]     signature;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: vectors completed this sweep and expected MISR value
    int          m_k;
    logic [31:0] m_sig;

    q65_sweep_ctrl #(
        .NSIG(NSIG), .NTICKS(NTICKS), .RW(RW), .TIMEOUT(TIMEOUT),
        .MISR_POLY(POLY), .MISR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec(vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .resp(resp), .resp_valid(resp_valid), .tick(tick),
        .busy(busy), .done(done), .err(err), .signature(signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] misr_model(input logic [31:0] s, input logic [7:0] r);
        logic [31:0] n;
        n = s << 1;
        if (s[31]) n = n ^ POLY;
        return n ^ {24'h0, r};
    endfunction

    function automatic logic [31:0] exp_sig();
`ifdef Q65_SWEEP_MISR_EN
        return m_sig;
`else
        return 32'h0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one full vector transaction, entered with the DUT presenting a vector
    task automatic do_vec(input int rdy_gap, input int rsp_gap);
        logic [7:0]      r;
        logic [NSIG-1:0] ev;
        ev = NSIG'(m_k % (1 << NSIG));
        chk("drv_valid", 32'(vec_valid), 32'd1);
        chk("drv_vec", 32'(vec), 32'(ev));
        chk("drv_tick", tick, 32'(m_k));
        for (int i = 0; i < rdy_gap; i++) begin
            vec_ready  = 1'b0;
            resp_valid = 1'($urandom_range(0, 1));
            resp       = 8'($urandom);
            step();
            chk("hold_valid", 32'(vec_valid), 32'd1);
            chk("hold_vec", 32'(vec), 32'(ev));
            chk("hold_tick", tick, 32'(m_k));
            chk("hold_sig", signature, exp_sig());
        end
        vec_ready  = 1'b1;
        resp_valid = 1'b0;
        step();
        vec_ready = 1'b0;
        chk("hs_valid", 32'(vec_valid), 32'd0);
        chk("hs_busy", 32'(busy), 32'd1);
        for (int i = 0; i < rsp_gap; i++) step();
        r          = 8'($urandom);
        resp       = r;
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        m_k++;
        m_sig = misr_model(m_sig, r);
        chk("resp_tick", tick, 32'(m_k));
        chk("resp_sig", signature, exp_sig());
    endtask

    task automatic begin_sweep();
        start = 1'b1;
        step();
        start = 1'b0;
        m_k   = 0;
        m_sig = SEED;
        chk("st_busy", 32'(busy), 32'd1);
        chk("st_done", 32'(done), 32'd0);
        chk("st_err", 32'(err), 32'd0);
        chk("st_sig", signature, exp_sig());
    endtask

    task automatic run_sweep(input int rdy_max, input int rsp_max);
        begin_sweep();
        for (int v = 0; v < int'(NTICKS); v++)
            do_vec(int'($urandom_range(0, rdy_max)), int'($urandom_range(0, rsp_max)));
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_err", 32'(err), 32'd0);
        chk("end_valid", 32'(vec_valid), 32'd0);
        chk("end_tick", tick, NTICKS);
        chk("end_vec", 32'(vec), (NTICKS - 1) % (1 << NSIG));
        step();
        chk("done_hold", 32'(done), 32'd1);
        chk("done_tick", tick, NTICKS);
        chk("done_sig", signature, exp_sig());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        vec_ready = 1'b0; resp = '0; resp_valid = 1'b0;
        m_k = 0; m_sig = SEED;
        step();
        step();
        rst = 1'b0;
        chk("rst_vec", 32'(vec), 32'd0);
        chk("rst_valid", 32'(vec_valid), 32'd0);
        chk("rst_tick", tick, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sig", signature, exp_sig());

        run_sweep(0, 0);
        run_sweep(3, 3);

        // timeout: handshake then silence for TIMEOUT cycles
        begin_sweep();
        vec_ready = 1'b1;
        step();
        vec_ready = 1'b0;
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) step();
        chk("tmo_early_done", 32'(done), 32'd0);
        chk("tmo_early_busy", 32'(busy), 32'd1);
        step();
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_tick", tick, 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_sig", signature, exp_sig());

        // abort in WAIT_RESP at vec=2
        begin_sweep();
        chk("restart_err", 32'(err), 32'd0);
        do_vec(1, 0);
        do_vec(0, 2);
        vec_ready = 1'b1;
        step();
        vec_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_valid", 32'(vec_valid), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_err", 32'(err), 32'd0);
        chk("ab_tick", tick, 32'd2);
        chk("ab_vec", 32'(vec), 32'd2);
        chk("ab_sig", signature, exp_sig());

        // start and abort together in IDLE: abort wins, nothing moves
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_vec", 32'(vec), 32'd2);
        chk("sa_tick", tick, 32'd2);

        run_sweep(2, 1);

        // start and abort together in DONE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sad_done", 32'(done), 32'd0);
        chk("sad_busy", 32'(busy), 32'd0);
        chk("sad_tick", tick, NTICKS);

        // start while busy is ignored, then rst mid-sweep
        begin_sweep();
        do_vec(0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sb_vec", 32'(vec), 32'd1);
        chk("sb_tick", tick, 32'd1);
        chk("sb_valid", 32'(vec_valid), 32'd1);
        chk("sb_sig", signature, exp_sig());
        vec_ready = 1'b1;
        step();
        vec_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sbw_busy", 32'(busy), 32'd1);
        chk("sbw_valid", 32'(vec_valid), 32'd0);
        chk("sbw_tick", tick, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_sig = SEED;
        chk("mrst_vec", 32'(vec), 32'd0);
        chk("mrst_valid", 32'(vec_valid), 32'd0);
        chk("mrst_tick", tick, 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_sig", signature, exp_sig());

        for (int s = 0; s < 4; s++) run_sweep(4, int'(TIMEOUT) - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
